mem_checker_core: RTL and testbench
===================================

Name: mem_checker_core

Overview:
- Single-clock memory test engine. Avalon-MM CSR slave accepts configuration and start commands from the system side.
- Avalon-MM burst master writes a data pattern over an address range, reads it back and counts mismatches.
- Sits between the system CSR bus and the external memory controller port.

Parameters:
AMM_ADDR_W, 28, memory word-address width
AMM_DATA_W, 64, memory data width; multiple of 32
AMM_BURST_W, 8, burstcount width; max burst 2**(AMM_BURST_W-1)

Ports:
clk_sys_i  in  1  single clock for CSR and memory sides
rst_i  in  1  synchronous, active-high reset
sys_read_i  in  1  CSR read strobe
sys_write_i  in  1  CSR write strobe
sys_address_i  in  4  CSR word address
sys_writedata_i  in  32  CSR write data
sys_readdatavalid_o  out  1  CSR read data valid
sys_readdata_o  out  32  CSR read data
mem_readdatavalid_i  in  1  memory read beat valid
mem_readdata_i  in  AMM_DATA_W  memory read beat
mem_waitrequest_i  in  1  memory stall
mem_address_o  out  AMM_ADDR_W  burst start word address
mem_read_o  out  1  read burst request
mem_write_o  out  1  write beat
mem_writedata_o  out  AMM_DATA_W  write beat data
mem_burstcount_o  out  AMM_BURST_W  burst length
mem_byteenable_o  out  AMM_DATA_W/8  always all ones

Behaviour:
- Reset: all outputs 0 except byteenable all ones. CSRs are 0 except BURST_LEN=1. FSM goes to IDLE.
- Reset mid-test aborts immediately and drops read/write the next cycle.
- CSR map (word addresses):
  - 0 CTRL: write bit0=1 starts a test; read bit0 returns busy.
  - 1 CFG: [1:0] mode (0 write-only, 1 read-only, 2 write-then-read, 3 treated as 2); [2] pattern (0 fixed, 1 address-incrementing).
  - 2 START_ADDR.
  - 3 END_ADDR (inclusive).
  - 4 BURST_LEN: 0 is stored as 1; values above max are clamped to max.
  - 5 PATTERN.
  - 6 STATUS: [0] done, [1] error seen.
  - 7 ERR_CNT: saturates at 0xFFFFFFFF.
  - 8 FIRST_ERR_ADDR.
  - 9 see Optional Feature.
  - Other addresses read 0.
- CSR reads: readdatavalid and readdata are registered, with 1-cycle latency. Back-to-back reads are supported.
- CSR writes to addresses 1-5 while busy are ignored.
- A start while busy is ignored.
- A start clears done, error seen, ERR_CNT and FIRST_ERR_ADDR.
- Expected word for address A: PATTERN replicated AMM_DATA_W/32 times (fixed mode), or (PATTERN + A[31:0]) replicated (incrementing mode), with 32-bit wrap.
- FSM states: IDLE -> WR_BURST -> RD_REQ -> RD_DATA -> DONE -> IDLE.
  - Write-only mode skips the read states.
  - Read-only mode skips WR_BURST.
- WR_BURST:
  - Address and burstcount are held stable for the whole burst.
  - A beat transfers when write && !waitrequest. Data advances only on a transfer.
  - The next burst starts on the cycle after the last beat, with no idle cycles required.
- RD_REQ: read is asserted until accepted (!waitrequest), then deasserted.
- RD_DATA:
  - Waits for burstcount readdatavalid beats and compares each beat.
  - Only one read burst is outstanding at a time.
- Burst length = min(BURST_LEN, words remaining); the final burst is shortened accordingly.
- On a mismatch:
  - ERR_CNT increments.
  - On the first error, the beat address is latched into FIRST_ERR_ADDR and error seen is set.
- DONE: busy clears and done sets, 1 cycle after the final beat.
- If START_ADDR > END_ADDR: no memory traffic; done=1 two cycles after start; error seen=0.
- readdatavalid outside RD_DATA is ignored.

Optional Feature:
- Macro: MEM_CHECKER_TIMER_EN.
- Defined: CSR 9 is a 32-bit cycle counter. It clears on start, increments each busy cycle, saturates, and holds after done.
- Undefined: CSR 9 reads 0, and no counter logic is generated.

Test Plan:
- CSR loopback: write 0x1234 to PATTERN, read it back -> readdatavalid exactly 1 cycle after read, data 0x1234. Read address 15 -> 0.
- Write-only: START=0, END=7, BURST_LEN=4, fixed pattern 0xA5A5A5A5, no waitrequest -> two bursts of 4 at addresses 0 and 4, 8 write beats all 0xA5A5A5A5_A5A5A5A5, then done=1.
- Write-then-read against an ideal memory model: START=16, END=25, BURST_LEN=4, incrementing pattern, random waitrequest -> bursts 4,4,2, ERR_CNT=0, STATUS=0b01.
- Error injection: the model corrupts the word at address 18 in the previous test -> ERR_CNT=1, FIRST_ERR_ADDR=18, STATUS=0b11.
- Edge cases:
  - START=5, END=3 -> no mem traffic, done.
  - Start while busy -> ignored.
  - BURST_LEN=0 -> bursts of 1.
- Reset mid-read burst -> all mem outputs low next cycle, CTRL busy=0, CSRs defaulted. With MEM_CHECKER_TIMER_EN, a completed test reports a nonzero CSR 9.

Source files
------------

// File: rtl/mem_checker_core.sv
// mem_checker_core: Avalon-MM memory tester that writes a pattern over a range and reads it back.
// Define MEM_CHECKER_TIMER_EN to add the busy-cycle counter at CSR 9.
module mem_checker_core #(
    parameter int AMM_ADDR_W  = 28,
    parameter int AMM_DATA_W  = 64,
    parameter int AMM_BURST_W = 8
) (
    input  logic                    clk_sys_i,
    input  logic                    rst_i,
    input  logic                    sys_read_i,
    input  logic                    sys_write_i,
    input  logic [3:0]              sys_address_i,
    input  logic [31:0]             sys_writedata_i,
    output logic                    sys_readdatavalid_o,
    output logic [31:0]             sys_readdata_o,
    input  logic                    mem_readdatavalid_i,
    input  logic [AMM_DATA_W-1:0]   mem_readdata_i,
    input  logic                    mem_waitrequest_i,
    output logic [AMM_ADDR_W-1:0]   mem_address_o,
    output logic                    mem_read_o,
    output logic                    mem_write_o,
    output logic [AMM_DATA_W-1:0]   mem_writedata_o,
    output logic [AMM_BURST_W-1:0]  mem_burstcount_o,
    output logic [AMM_DATA_W/8-1:0] mem_byteenable_o
);

    localparam int AW = AMM_ADDR_W;
    localparam int BW = AMM_BURST_W;
    localparam int NW = AMM_DATA_W / 32;
    localparam int CW = (AW + 1 > BW) ? AW + 1 : BW;

    localparam logic [BW-1:0] MAX_BURST = {1'b1, {(BW-1){1'b0}}};
    localparam logic [BW-1:0] ONE_BURST = {{(BW-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE,
        WR_BURST,
        RD_REQ,
        RD_DATA,
        DONE
    } state_t;

    state_t state;

    logic [1:0]    cfg_mode;
    logic          cfg_pat_inc;
    logic [AW-1:0] start_addr;
    logic [AW-1:0] end_addr;
    logic [BW-1:0] burst_len;
    logic [31:0]   pattern;

    logic          done;
    logic          err_seen;
    logic [31:0]   err_cnt;
    logic [AW-1:0] first_err_addr;

    logic [AW-1:0] beat_addr;
    logic [BW-1:0] beat_cnt;

    logic [31:0]   csr_rdata;
    logic [31:0]   timer_rd;

    logic          busy;
    logic          start;
    logic          do_write;
    logic          do_read;
    logic          last_beat;
    logic          last_word;
    logic [AW-1:0] next_addr;

    assign busy      = (state != IDLE);
    assign start     = sys_write_i && (sys_address_i == 4'd0)
                       && sys_writedata_i[0] && !busy;
    assign do_write  = (cfg_mode != 2'd1);
    assign do_read   = (cfg_mode != 2'd0);
    assign last_beat = (beat_cnt == (mem_burstcount_o - 1'b1));
    assign last_word = (beat_addr == end_addr);
    assign next_addr = beat_addr + 1'b1;

    assign mem_byteenable_o = '1;

    function automatic logic [AMM_DATA_W-1:0] pat_word(input logic [AW-1:0] a);
        logic [31:0] w;
        w = cfg_pat_inc ? (pattern + 32'(a)) : pattern;
        return {NW{w}};
    endfunction

    // Burst never runs past END_ADDR: the tail burst is cut to the words left.
    function automatic logic [BW-1:0] burst_for(input logic [AW-1:0] a);
        logic [CW-1:0] rem;
        rem = CW'(end_addr) - CW'(a) + CW'(1);
        if (rem < CW'(burst_len)) begin
            return rem[BW-1:0];
        end
        return burst_len;
    endfunction

    always_ff @(posedge clk_sys_i) begin
        if (rst_i) begin
            cfg_mode    <= 2'd0;
            cfg_pat_inc <= 1'b0;
            start_addr  <= '0;
            end_addr    <= '0;
            burst_len   <= ONE_BURST;
            pattern     <= 32'd0;
        end else if (sys_write_i && !busy) begin
            case (sys_address_i)
                4'd1: begin
                    cfg_mode    <= sys_writedata_i[1:0];
                    cfg_pat_inc <= sys_writedata_i[2];
                end
                4'd2: start_addr <= AW'(sys_writedata_i);
                4'd3: end_addr   <= AW'(sys_writedata_i);
                4'd4: begin
                    if (sys_writedata_i == 32'd0) begin
                        burst_len <= ONE_BURST;
                    end else if (sys_writedata_i > 32'(MAX_BURST)) begin
                        burst_len <= MAX_BURST;
                    end else begin
                        burst_len <= sys_writedata_i[BW-1:0];
                    end
                end
                4'd5: pattern <= sys_writedata_i;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_sys_i) begin
        if (rst_i) begin
            state            <= IDLE;
            mem_address_o    <= '0;
            mem_burstcount_o <= '0;
            mem_writedata_o  <= '0;
            mem_read_o       <= 1'b0;
            mem_write_o      <= 1'b0;
            beat_addr        <= '0;
            beat_cnt         <= '0;
            done             <= 1'b0;
            err_seen         <= 1'b0;
            err_cnt          <= 32'd0;
            first_err_addr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        done             <= 1'b0;
                        err_seen         <= 1'b0;
                        err_cnt          <= 32'd0;
                        first_err_addr   <= '0;
                        mem_address_o    <= start_addr;
                        mem_burstcount_o <= burst_for(start_addr);
                        mem_writedata_o  <= pat_word(start_addr);
                        beat_addr        <= start_addr;
                        beat_cnt         <= '0;
                        if (start_addr > end_addr) begin
                            state <= DONE;
                        end else if (!do_write) begin
                            mem_read_o <= 1'b1;
                            state      <= RD_REQ;
                        end else begin
                            mem_write_o <= 1'b1;
                            state       <= WR_BURST;
                        end
                    end
                end
                WR_BURST: begin
                    if (!mem_waitrequest_i) begin
                        beat_addr       <= next_addr;
                        beat_cnt        <= beat_cnt + 1'b1;
                        mem_writedata_o <= pat_word(next_addr);
                        if (last_beat) begin
                            beat_cnt <= '0;
                            if (!last_word) begin
                                mem_address_o    <= next_addr;
                                mem_burstcount_o <= burst_for(next_addr);
                            end else begin
                                mem_write_o <= 1'b0;
                                if (do_read) begin
                                    mem_address_o    <= start_addr;
                                    mem_burstcount_o <= burst_for(start_addr);
                                    mem_read_o       <= 1'b1;
                                    state            <= RD_REQ;
                                end else begin
                                    state <= DONE;
                                end
                            end
                        end
                    end
                end
                RD_REQ: begin
                    if (!mem_waitrequest_i) begin
                        mem_read_o <= 1'b0;
                        beat_addr  <= mem_address_o;
                        beat_cnt   <= '0;
                        state      <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (mem_readdatavalid_i) begin
                        if (mem_readdata_i != pat_word(beat_addr)) begin
                            if (err_cnt != '1) begin
                                err_cnt <= err_cnt + 32'd1;
                            end
                            if (!err_seen) begin
                                err_seen       <= 1'b1;
                                first_err_addr <= beat_addr;
                            end
                        end
                        beat_addr <= next_addr;
                        beat_cnt  <= beat_cnt + 1'b1;
                        if (last_beat) begin
                            if (last_word) begin
                                state <= DONE;
                            end else begin
                                mem_address_o    <= next_addr;
                                mem_burstcount_o <= burst_for(next_addr);
                                mem_read_o       <= 1'b1;
                                state            <= RD_REQ;
                            end
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_CHECKER_TIMER_EN
    logic [31:0] cyc_cnt;

    always_ff @(posedge clk_sys_i) begin
        if (rst_i) begin
            cyc_cnt <= 32'd0;
        end else if (start) begin
            cyc_cnt <= 32'd0;
        end else if (busy && (cyc_cnt != '1)) begin
            cyc_cnt <= cyc_cnt + 32'd1;
        end
    end

    assign timer_rd = cyc_cnt;
`else
    assign timer_rd = 32'd0;
`endif

    always_comb begin
        csr_rdata = 32'd0;
        case (sys_address_i)
            4'd0: csr_rdata = {31'd0, busy};
            4'd1: csr_rdata = {29'd0, cfg_pat_inc, cfg_mode};
            4'd2: csr_rdata = 32'(start_addr);
            4'd3: csr_rdata = 32'(end_addr);
            4'd4: csr_rdata = 32'(burst_len);
            4'd5: csr_rdata = pattern;
            4'd6: csr_rdata = {30'd0, err_seen, done};
            4'd7: csr_rdata = err_cnt;
            4'd8: csr_rdata = 32'(first_err_addr);
            4'd9: csr_rdata = timer_rd;
            default: csr_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk_sys_i) begin
        if (rst_i) begin
            sys_readdatavalid_o <= 1'b0;
            sys_readdata_o      <= 32'd0;
        end else begin
            sys_readdatavalid_o <= sys_read_i;
            sys_readdata_o      <= sys_read_i ? csr_rdata : 32'd0;
        end
    end

endmodule

// File: tb/tb_mem_checker_core.sv
// tb_mem_checker_core: directed bench for mem_checker_core with a small burst memory model.
// Build with MEM_CHECKER_TIMER_EN to also cover the cycle counter at CSR 9.
`timescale 1ns/1ps
module tb_mem_checker_core;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        sys_read_i = 1'b0;
    logic        sys_write_i = 1'b0;
    logic [3:0]  sys_address_i = 4'd0;
    logic [31:0] sys_writedata_i = 32'd0;
    logic        sys_readdatavalid_o;
    logic [31:0] sys_readdata_o;
    logic        mem_readdatavalid_i = 1'b0;
    logic [63:0] mem_readdata_i = 64'd0;
    logic        mem_waitrequest_i = 1'b0;
    logic [27:0] mem_address_o;
    logic        mem_read_o;
    logic        mem_write_o;
    logic [63:0] mem_writedata_o;
    logic [7:0]  mem_burstcount_o;
    logic [7:0]  mem_byteenable_o;

    always #5 clk = ~clk;

    mem_checker_core dut (
        .clk_sys_i           (clk),
        .rst_i               (rst_i),
        .sys_read_i          (sys_read_i),
        .sys_write_i         (sys_write_i),
        .sys_address_i       (sys_address_i),
        .sys_writedata_i     (sys_writedata_i),
        .sys_readdatavalid_o (sys_readdatavalid_o),
        .sys_readdata_o      (sys_readdata_o),
        .mem_readdatavalid_i (mem_readdatavalid_i),
        .mem_readdata_i      (mem_readdata_i),
        .mem_waitrequest_i   (mem_waitrequest_i),
        .mem_address_o       (mem_address_o),
        .mem_read_o          (mem_read_o),
        .mem_write_o         (mem_write_o),
        .mem_writedata_o     (mem_writedata_o),
        .mem_burstcount_o    (mem_burstcount_o),
        .mem_byteenable_o    (mem_byteenable_o)
    );

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory model: random stall, burst bookkeeping, one word can be corrupted on read.
    logic [63:0] mem [0:63];
    int wb_addr[$];
    int wb_len[$];
    int rb_addr[$];
    int rb_len[$];
    bit rand_wait = 0;
    int corrupt_addr = -1;
    int beats_w = 0;
    int rd_beats = 0;
    int w_base, w_left, w_idx;
    int p_addr, p_left;
    bit p_act = 0;
    int cyc = 0;
    int wr_first, wr_last;
    bit wn;
    logic [63:0] rv;

    always @(negedge clk) begin
        cyc++;
        if (rst_i) begin
            p_act = 0;
            w_left = 0;
            mem_readdatavalid_i = 1'b0;
            mem_waitrequest_i = 1'b0;
        end else begin
            mem_readdatavalid_i = 1'b0;
            if (p_act && (!rand_wait || $urandom_range(3) != 0)) begin
                rv = mem[p_addr % 64];
                if (p_addr == corrupt_addr) rv = rv ^ 64'd1;
                mem_readdata_i = rv;
                mem_readdatavalid_i = 1'b1;
                p_addr++;
                p_left--;
                rd_beats++;
                if (p_left == 0) p_act = 0;
            end
            wn = rand_wait ? ($urandom_range(2) == 0) : 1'b0;
            mem_waitrequest_i = wn;
            if (mem_write_o && !wn) begin
                if (w_left == 0) begin
                    w_base = int'(mem_address_o);
                    w_left = int'(mem_burstcount_o);
                    w_idx = 0;
                    wb_addr.push_back(w_base);
                    wb_len.push_back(w_left);
                end
                mem[(w_base + w_idx) % 64] = mem_writedata_o;
                w_idx++;
                w_left--;
                if (beats_w == 0) wr_first = cyc;
                wr_last = cyc;
                beats_w++;
            end
            if (mem_read_o && !wn) begin
                p_addr = int'(mem_address_o);
                p_left = int'(mem_burstcount_o);
                p_act = 1;
                rb_addr.push_back(p_addr);
                rb_len.push_back(p_left);
            end
        end
    end

    task automatic model_clear();
        wb_addr.delete();
        wb_len.delete();
        rb_addr.delete();
        rb_len.delete();
        beats_w = 0;
        rd_beats = 0;
        w_left = 0;
    endtask

    task automatic csr_wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        sys_write_i = 1'b1;
        sys_address_i = a;
        sys_writedata_i = d;
        @(negedge clk);
        sys_write_i = 1'b0;
    endtask

    task automatic csr_rd(input logic [3:0] a, output logic [31:0] d,
                          output logic v);
        @(negedge clk);
        sys_read_i = 1'b1;
        sys_address_i = a;
        @(negedge clk);
        sys_read_i = 1'b0;
        d = sys_readdata_o;
        v = sys_readdatavalid_o;
    endtask

    task automatic rd_check(input string tag, input logic [3:0] a,
                            input logic [31:0] exp);
        logic [31:0] d;
        logic v;
        csr_rd(a, d, v);
        check(tag, d, exp);
    endtask

    task automatic wait_done(input string tag);
        logic [31:0] st;
        logic v;
        bit ok;
        ok = 0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            csr_rd(4'd6, st, v);
            ok = st[0];
        end
        check({tag, "_done"}, ok, 1);
    endtask

    task automatic burst_check(input string tag, input int q_a, input int q_l,
                               input int ea, input int el);
        check({tag, "_addr"}, q_a, ea);
        check({tag, "_len"}, q_l, el);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] d;
        logic [31:0] w;
        logic v;
        int good;
        bit ok;
        int ea[3];
        int el[3];

        for (int i = 0; i < 64; i++) mem[i] = 64'd0;

        repeat (3) @(negedge clk);
        check("rst_write", mem_write_o, 0);
        check("rst_read", mem_read_o, 0);
        check("rst_be", mem_byteenable_o, 8'hFF);
        check("rst_rdvalid", sys_readdatavalid_o, 0);
        check("rst_addr", mem_address_o, 0);
        rst_i = 1'b0;
        rd_check("rst_burst_len", 4'd4, 32'd1);
        rd_check("rst_ctrl", 4'd0, 32'd0);
        rd_check("rst_status", 4'd6, 32'd0);
        rd_check("rst_pattern", 4'd5, 32'd0);

        // CSR loopback, latency and back-to-back reads
        csr_wr(4'd5, 32'h1234);
        csr_rd(4'd5, d, v);
        check("lb_valid", v, 1);
        check("lb_data", d, 32'h1234);
        @(negedge clk);
        check("lb_valid_drop", sys_readdatavalid_o, 0);
        rd_check("lb_addr15", 4'd15, 32'd0);
        @(negedge clk);
        sys_read_i = 1'b1;
        sys_address_i = 4'd5;
        @(negedge clk);
        sys_address_i = 4'd4;
        check("b2b_v0", sys_readdatavalid_o, 1);
        check("b2b_d0", sys_readdata_o, 32'h1234);
        @(negedge clk);
        sys_read_i = 1'b0;
        check("b2b_v1", sys_readdatavalid_o, 1);
        check("b2b_d1", sys_readdata_o, 32'd1);

        // Write-only, fixed pattern, no stalls
        csr_wr(4'd1, 32'd0);
        csr_wr(4'd2, 32'd0);
        csr_wr(4'd3, 32'd7);
        csr_wr(4'd4, 32'd4);
        csr_wr(4'd5, 32'hA5A5A5A5);
        rand_wait = 0;
        model_clear();
        csr_wr(4'd0, 32'd1);
        wait_done("wo");
        check("wo_nbursts", wb_addr.size(), 2);
        burst_check("wo_b0", wb_addr[0], wb_len[0], 0, 4);
        burst_check("wo_b1", wb_addr[1], wb_len[1], 4, 4);
        check("wo_beats", beats_w, 8);
        check("wo_no_gap", wr_last - wr_first, 7);
        check("wo_reads", rb_addr.size(), 0);
        good = 0;
        for (int i = 0; i < 8; i++) begin
            if (mem[i] == 64'hA5A5A5A5_A5A5A5A5) good++;
        end
        check("wo_data", good, 8);
        rd_check("wo_status", 4'd6, 32'd1);
        rd_check("wo_busy", 4'd0, 32'd0);

        // Write-then-read, incrementing pattern that wraps, random stalls
        ea = '{16, 20, 24};
        el = '{4, 4, 2};
        csr_wr(4'd1, 32'd6);
        csr_wr(4'd2, 32'd16);
        csr_wr(4'd3, 32'd25);
        csr_wr(4'd5, 32'hFFFFFFFE);
        rand_wait = 1;
        model_clear();
        csr_wr(4'd0, 32'd1);
        wait_done("wr");
        check("wr_nwb", wb_addr.size(), 3);
        check("wr_nrb", rb_addr.size(), 3);
        for (int i = 0; i < 3; i++) begin
            burst_check($sformatf("wr_wb%0d", i),
                        wb_addr.size() > i ? wb_addr[i] : -1,
                        wb_len.size() > i ? wb_len[i] : -1, ea[i], el[i]);
            burst_check($sformatf("wr_rb%0d", i),
                        rb_addr.size() > i ? rb_addr[i] : -1,
                        rb_len.size() > i ? rb_len[i] : -1, ea[i], el[i]);
        end
        good = 0;
        for (int i = 16; i <= 25; i++) begin
            w = 32'hFFFFFFFE + 32'(i);
            if (mem[i] == {w, w}) good++;
        end
        check("wr_data", good, 10);
        check("wr_word18", mem[18], 64'h00000010_00000010);
        rd_check("wr_errcnt", 4'd7, 32'd0);
        rd_check("wr_status", 4'd6, 32'd1);

        // Same test with mode 3 and one corrupted word on readback
        csr_wr(4'd1, 32'd7);
        corrupt_addr = 18;
        model_clear();
        csr_wr(4'd0, 32'd1);
        wait_done("ei");
        corrupt_addr = -1;
        check("ei_nrb", rb_addr.size(), 3);
        rd_check("ei_errcnt", 4'd7, 32'd1);
        rd_check("ei_first", 4'd8, 32'd18);
        rd_check("ei_status", 4'd6, 32'd3);

        // Empty range: no traffic, done, start clears error state
        rand_wait = 0;
        csr_wr(4'd2, 32'd5);
        csr_wr(4'd3, 32'd3);
        model_clear();
        csr_wr(4'd0, 32'd1);
        rd_check("er_status", 4'd6, 32'd1);
        rd_check("er_busy", 4'd0, 32'd0);
        rd_check("er_errcnt", 4'd7, 32'd0);
        rd_check("er_first", 4'd8, 32'd0);
        check("er_wbeats", beats_w, 0);
        check("er_reads", rb_addr.size(), 0);

        // BURST_LEN=0 gives single-beat bursts; writes and starts while busy are ignored
        csr_wr(4'd1, 32'd0);
        csr_wr(4'd2, 32'd0);
        csr_wr(4'd3, 32'd63);
        csr_wr(4'd4, 32'd0);
        rd_check("bl0_read", 4'd4, 32'd1);
        model_clear();
        csr_wr(4'd0, 32'd1);
        csr_wr(4'd2, 32'd40);
        csr_wr(4'd0, 32'd1);
        rd_check("bz_busy", 4'd0, 32'd1);
        rd_check("bz_start_kept", 4'd2, 32'd0);
        wait_done("bz");
        check("bz_nbursts", wb_addr.size(), 64);
        good = 0;
        for (int i = 0; i < wb_len.size(); i++) begin
            if (wb_len[i] == 1 && wb_addr[i] == i) good++;
        end
        check("bz_single", good, 64);
        check("bz_beats", beats_w, 64);
        csr_wr(4'd4, 32'd1000);
        rd_check("bl_clamp", 4'd4, 32'd128);

        // Reset in the middle of a read burst
        csr_wr(4'd1, 32'd1);
        csr_wr(4'd2, 32'd8);
        csr_wr(4'd4, 32'd8);
        csr_wr(4'd5, 32'h55);
        model_clear();
        csr_wr(4'd0, 32'd1);
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = (rd_beats >= 3);
        end
        check("mr_reached", ok, 1);
        rst_i = 1'b1;
        @(negedge clk);
        check("mr_read", mem_read_o, 0);
        check("mr_write", mem_write_o, 0);
        check("mr_addr", mem_address_o, 0);
        check("mr_bcnt", mem_burstcount_o, 0);
        check("mr_wdata", mem_writedata_o, 0);
        @(negedge clk);
        rst_i = 1'b0;
        rd_check("mr_busy", 4'd0, 32'd0);
        rd_check("mr_cfg", 4'd1, 32'd0);
        rd_check("mr_start", 4'd2, 32'd0);
        rd_check("mr_blen", 4'd4, 32'd1);
        rd_check("mr_pattern", 4'd5, 32'd0);
        rd_check("mr_status", 4'd6, 32'd0);

        // Short completed test, then the cycle counter
        csr_wr(4'd3, 32'd3);
        csr_wr(4'd4, 32'd4);
        model_clear();
        csr_wr(4'd0, 32'd1);
        wait_done("tm");
        check("tm_beats", beats_w, 4);
        csr_rd(4'd9, d, v);
`ifdef MEM_CHECKER_TIMER_EN
        check("tm_nonzero", (d != 32'd0), 1);
`else
        check("tm_zero", d, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
